// File: rtl/axi_stream_insert_header_bp.sv
// axi_stream_insert_header_bp: prepends a variable-length header to an AXI-Stream packet with full backpressure
module axi_stream_insert_header_bp #(
  parameter int DATA_WD = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter bit HDR_ALLOW_EMPTY = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      header_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert,
  output logic                    pkt_done
);
  localparam int CW = $clog2(DATA_BYTE_WD) + 1;
  localparam int SW = $clog2(DATA_BYTE_WD) + 2;
  localparam int BW = $clog2(DATA_WD) + 1;

  typedef enum logic [1:0] {IDLE, HDR, STREAM, TAIL} state_t;

  function automatic logic [CW-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
    popcnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) popcnt = popcnt + CW'(k[i]);
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] top_keep(input logic [SW-1:0] n);
    top_keep = ~({DATA_BYTE_WD{1'b1}} >> n);
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] low_keep(input logic [CW-1:0] n);
    low_keep = ~({DATA_BYTE_WD{1'b1}} << n);
  endfunction

  function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] k);
    for (int i = 0; i < DATA_BYTE_WD; i++) lane_mask[i*8 +: 8] = {8{k[i]}};
  endfunction

  state_t state_q, state_d;
  logic [CW-1:0] h_q, h_d, hdr_h, in_cnt;
  logic [SW-1:0] total;
  logic [BW-1:0] lo_sh, hi_sh;
  logic [DATA_WD-1:0] r_q, r_d, data_q, data_d, merged;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic valid_q, valid_d, last_q, last_d, arm_q, arm_d;
  logic out_free, hdr_fire, in_fire;

  // Handshakes and the byte-alignment datapath: residual bytes on top, fresh input bytes below
  always_comb begin
    out_free = !valid_q || ready_out;
    ready_insert = arm_q && state_q == IDLE;
    ready_in = (state_q == HDR || state_q == STREAM) && out_free;
    hdr_fire = valid_insert && ready_insert;
    in_fire = valid_in && ready_in;
    hdr_h = popcnt(keep_insert);
    in_cnt = popcnt(keep_in);
    total = SW'(h_q) + SW'(in_cnt);
    lo_sh = BW'(h_q) << 3;
    hi_sh = BW'(DATA_BYTE_WD - int'(h_q)) << 3;
    merged = (r_q << hi_sh) | (data_in >> lo_sh);
  end

  // Next state, residual bookkeeping and output register load; the register holds while stalled
  always_comb begin
    state_d = state_q;
    h_d = h_q;
    r_d = r_q;
    valid_d = valid_q && !ready_out;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    arm_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (hdr_fire && (hdr_h != '0 || HDR_ALLOW_EMPTY)) begin
          state_d = HDR;
          h_d = hdr_h;
          r_d = header_insert & lane_mask(low_keep(hdr_h));
        end
      end
      HDR, STREAM: begin
        if (in_fire) begin
          valid_d = 1'b1;
          if (!last_in) begin
            data_d = merged;
            keep_d = '1;
            last_d = 1'b0;
            r_d = data_in & lane_mask(low_keep(h_q));
            state_d = STREAM;
          end else if (total <= SW'(DATA_BYTE_WD)) begin
            data_d = merged & lane_mask(top_keep(total));
            keep_d = top_keep(total);
            last_d = 1'b1;
            h_d = '0;
            r_d = '0;
            state_d = IDLE;
          end else begin
            data_d = merged;
            keep_d = '1;
            last_d = 1'b0;
            h_d = CW'(total - SW'(DATA_BYTE_WD));
            r_d = (data_in << hi_sh) & lane_mask(top_keep(total - SW'(DATA_BYTE_WD)));
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        if (out_free) begin
          valid_d = 1'b1;
          data_d = r_q;
          keep_d = top_keep(SW'(h_q));
          last_d = 1'b1;
          h_d = '0;
          r_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q <= '0;
      r_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      r_q <= r_d;
      valid_q <= valid_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
      arm_q <= arm_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out = data_q;
  assign keep_out = keep_q;
  assign last_out = last_q;
  assign pkt_done = valid_q && ready_out && last_q;
endmodule

// File: tb/tb_axi_stream_insert_header_bp.sv
// tb_axi_stream_insert_header_bp: directed table plus randomized byte-queue model check of the header inserter
module tb_axi_stream_insert_header_bp;
  localparam int DW = 32;
  localparam int NB = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_in = 1'b0, last_in = 1'b0, ready_out = 1'b1, valid_insert = 1'b0;
  logic [DW-1:0] data_in = '0, header_insert = '0;
  logic [NB-1:0] keep_in = '0, keep_insert = '0;
  logic ready_in, valid_out, last_out, ready_insert, pkt_done;
  logic [DW-1:0] data_out;
  logic [NB-1:0] keep_out;

  typedef struct {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic l;
    logic done;
  } beat_t;

  typedef struct {
    string name;
    logic [DW-1:0] hdr;
    logic [NB-1:0] hk;
    int n;
    logic [2:0][DW-1:0] d;
    logic [2:0][NB-1:0] k;
    int m;
    logic [2:0][DW-1:0] ed;
    logic [2:0][NB-1:0] ek;
    logic [2:0] el;
    bit rnd;
  } vec_t;

  int checks = 0, errors = 0;
  bit rnd_rdy = 1'b0;
  beat_t cap[$], expq[$];
  vec_t vt[5];

  always #5 clk = ~clk;

  axi_stream_insert_header_bp #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .header_insert(header_insert), .keep_insert(keep_insert),
    .ready_insert(ready_insert), .pkt_done(pkt_done)
  );

  function automatic vec_t mk(string nm, logic [DW-1:0] hdr, logic [NB-1:0] hk, int n,
                              logic [2:0][DW-1:0] d, logic [2:0][NB-1:0] k, int m,
                              logic [2:0][DW-1:0] ed, logic [2:0][NB-1:0] ek, logic [2:0] el, bit rnd);
    mk.name = nm; mk.hdr = hdr; mk.hk = hk; mk.n = n; mk.d = d; mk.k = k;
    mk.m = m; mk.ed = ed; mk.ek = ek; mk.el = el; mk.rnd = rnd;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_hdr(input logic [DW-1:0] h, input logic [NB-1:0] k);
    int t = 0;
    bit f;
    valid_insert = 1'b1; header_insert = h; keep_insert = k;
    do begin @(negedge clk); f = ready_insert; @(posedge clk); #1; t++; end while (!f && t < 300);
    chk("hdr_accept", 32'(f), 32'd1);
    valid_insert = 1'b0; keep_insert = '0; header_insert = $urandom;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
    int t = 0;
    bit f;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    do begin @(negedge clk); f = ready_in; @(posedge clk); #1; t++; end while (!f && t < 300);
    chk("beat_accept", 32'(f), 32'd1);
    valid_in = 1'b0; last_in = 1'b0; keep_in = '0; data_in = $urandom;
  endtask

  task automatic send_vec(input vec_t v);
    send_hdr(v.hdr, v.hk);
    for (int i = 0; i < v.n; i++) send_beat(v.d[i], v.k[i], i == v.n - 1);
  endtask

  task automatic push_vec_exp(input vec_t v);
    for (int i = 0; i < v.m; i++) expq.push_back('{v.ed[i], v.ek[i], v.el[i], v.el[i]});
  endtask

  task automatic settle(input int m);
    int t = 0;
    while (cap.size() < m && t < 3000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic compare(input string nm);
    beat_t a, e;
    chk({nm, "_count"}, 32'(cap.size()), 32'(expq.size()));
    while (expq.size() > 0 && cap.size() > 0) begin
      a = cap.pop_front();
      e = expq.pop_front();
      chk({nm, "_data"}, a.d, e.d);
      chk({nm, "_keep"}, 32'(a.k), 32'(e.k));
      chk({nm, "_last"}, 32'(a.l), 32'(e.l));
      chk({nm, "_pkt_done"}, 32'(a.done), 32'(e.done));
    end
    expq.delete();
    cap.delete();
  endtask

  initial begin
    logic stalled_p;
    logic [DW-1:0] pd_s;
    logic [NB-1:0] pk_s;
    logic pl_s;
    vt[0] = mk("hdr2", 32'h0000BBBB, 4'b0011, 3,
               {32'h99AA0000, 32'h55667788, 32'h11223344}, {4'b1100, 4'hF, 4'hF}, 3,
               {32'h778899AA, 32'h33445566, 32'hBBBB1122}, {4'hF, 4'hF, 4'hF}, 3'b100, 1'b0);
    vt[1] = mk("hdr3_tail", 32'h00CCDDEE, 4'b0111, 1,
               {32'h0, 32'h0, 32'h11223344}, {4'h0, 4'h0, 4'hF}, 2,
               {32'h0, 32'h22334400, 32'hCCDDEE11}, {4'h0, 4'b1110, 4'hF}, 3'b010, 1'b0);
    vt[2] = mk("hdr0_pass", 32'h12345678, 4'b0000, 2,
               {32'h0, 32'hCAFE0000, 32'hDEADBEEF}, {4'h0, 4'b1100, 4'hF}, 2,
               {32'h0, 32'hCAFE0000, 32'hDEADBEEF}, {4'h0, 4'b1100, 4'hF}, 3'b010, 1'b0);
    vt[3] = vt[0];
    vt[3].name = "hdr2_stall";
    vt[3].rnd = 1'b1;
    vt[4] = mk("hdr4_tail", 32'hA1A2A3A4, 4'b1111, 1,
               {32'h0, 32'h0, 32'h01020304}, {4'h0, 4'h0, 4'b1000}, 2,
               {32'h0, 32'h01000000, 32'hA1A2A3A4}, {4'h0, 4'b1000, 4'hF}, 3'b010, 1'b0);
    stalled_p = 1'b0; pd_s = '0; pk_s = '0; pl_s = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (rst_n && valid_out && ready_out) cap.push_back('{data_out, keep_out, last_out, pkt_done});
        if (rst_n && stalled_p) begin
          chk("stall_valid", 32'(valid_out), 32'd1);
          chk("stall_data", data_out, pd_s);
          chk("stall_keep_last", {27'd0, pk_s, pl_s}, {27'd0, keep_out, last_out});
        end
        if (rst_n && valid_out && !ready_out) chk("stall_ready_in", 32'(ready_in), 32'd0);
        stalled_p = rst_n && valid_out && !ready_out;
        pd_s = data_out; pk_s = keep_out; pl_s = last_out;
      end
      forever begin
        @(posedge clk); #1;
        ready_out = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
      end
    join_none

    #12;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_keep_last", {27'd0, keep_out, last_out}, 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd0);
    chk("rst_ready_insert", 32'(ready_insert), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready_insert", 32'(ready_insert), 32'd1);

    for (int v = 0; v < 5; v++) begin
      rnd_rdy = vt[v].rnd;
      push_vec_exp(vt[v]);
      send_vec(vt[v]);
      settle(vt[v].m);
      compare(vt[v].name);
    end

    rnd_rdy = 1'b0;
    push_vec_exp(vt[0]);
    push_vec_exp(vt[4]);
    send_vec(vt[0]);
    valid_insert = 1'b1; header_insert = vt[4].hdr; keep_insert = vt[4].hk;
    @(negedge clk);
    chk("b2b_hdr_idle", 32'(ready_insert), 32'd1);
    @(posedge clk); #1;
    valid_insert = 1'b0; keep_insert = '0;
    send_beat(vt[4].d[0], vt[4].k[0], 1'b1);
    settle(5);
    compare("b2b");

    send_hdr(vt[0].hdr, vt[0].hk);
    send_beat(vt[0].d[0], vt[0].k[0], 1'b0);
    chk("pre_rst_valid", 32'(valid_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_out", 32'(valid_out), 32'd0);
    chk("mid_rst_data_out", data_out, 32'd0);
    chk("mid_rst_keep_last", {27'd0, keep_out, last_out}, 32'd0);
    chk("mid_rst_ready", {30'd0, ready_in, ready_insert}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready_insert", 32'(ready_insert), 32'd1);
    push_vec_exp(vt[1]);
    send_vec(vt[1]);
    settle(2);
    compare("after_rst");

    rnd_rdy = 1'b1;
    for (int p = 0; p < 30; p++) begin
      int hn, nb, dl, cnt;
      logic [DW-1:0] h;
      logic [DW-1:0] pd[4];
      logic [7:0] bq[$];
      beat_t e;
      hn = $urandom_range(0, 4);
      nb = $urandom_range(1, 4);
      dl = $urandom_range(1, 4);
      h = $urandom;
      for (int b = 0; b < 4; b++) pd[b] = $urandom;
      for (int i = NB - hn; i < NB; i++) bq.push_back(h[8*(NB-1-i) +: 8]);
      for (int b = 0; b < nb; b++) begin
        cnt = (b == nb - 1) ? dl : NB;
        for (int i = 0; i < cnt; i++) bq.push_back(pd[b][8*(NB-1-i) +: 8]);
      end
      while (bq.size() > 0) begin
        e.d = '0; e.k = '0;
        cnt = (bq.size() < NB) ? bq.size() : NB;
        for (int i = 0; i < cnt; i++) begin
          e.d[8*(NB-1-i) +: 8] = bq.pop_front();
          e.k[NB-1-i] = 1'b1;
        end
        e.l = bq.size() == 0;
        e.done = e.l;
        expq.push_back(e);
      end
      send_hdr(h, 4'((5'd1 << hn) - 5'd1));
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        send_beat(pd[b], (b == nb - 1) ? 4'(8'hF0 >> dl) : 4'hF, b == nb - 1);
      end
    end
    settle(expq.size());
    compare("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_stream_insert_header_bp.md
AXI_STREAM_INSERT_HEADER_BP -- requirements
Module: axi_stream_insert_header_bp

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, meaning stream data width in bits; it shall be a multiple of 8 and at least 16.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, meaning bytes per beat.
REQ-003 SHALL have parameter HDR_ALLOW_EMPTY, default 1, meaning keep_insert of all zeros is accepted as a zero-byte header, giving pass-through.
REQ-004 Ports, one per line, as name, direction, width, meaning:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- valid_in, in, 1, input data valid.
- data_in, in, DATA_WD, input data.
- keep_in, in, DATA_BYTE_WD, input byte enables, MSB-aligned.
- last_in, in, 1, input end of packet.
- ready_in, out, 1, input data ready.
- valid_out, out, 1, output valid.
- data_out, out, DATA_WD, output data.
- keep_out, out, DATA_BYTE_WD, output byte enables, MSB-aligned.
- last_out, out, 1, output end of packet.
- ready_out, in, 1, output ready.
- valid_insert, in, 1, header valid.
- header_insert, in, DATA_WD, header data.
- keep_insert, in, DATA_BYTE_WD, header byte enables, LSB-aligned.
- ready_insert, out, 1, header ready.
- pkt_done, out, 1, one-cycle pulse on the output last beat handshake.

Function
REQ-005 Transfer SHALL occur on a channel only in a cycle where valid and ready are both 1; byte 0 is data[DATA_WD-1 -: 8].
REQ-006 FSM states SHALL be: IDLE, HDR, STREAM, TAIL.
- IDLE: ready_insert=1 and ready_in=0; header fire goes to HDR.
REQ-007 Header fire SHALL latch H = the number of set keep_insert bits (0..DATA_BYTE_WD) and the low H header bytes into a residual register R.
- If H=0 and HDR_ALLOW_EMPTY=0, the header shall be ignored and the state stays IDLE.
REQ-008 HDR/STREAM SHALL have ready_in = !valid_out || ready_out (output register free or being drained); ready_insert=0.
REQ-009 Each non-last input fire SHALL load the output register with {R, top DATA_BYTE_WD-H input bytes}, keep_out all ones, and last_out=0.
- The low H input bytes shall become the new R.
- With H=0 the input beat shall pass through unchanged.
REQ-010 For a last input fire with D = set keep_in bits, if H+D <= DATA_BYTE_WD the block SHALL emit one beat.
- That beat shall carry the H+D valid bytes MSB-aligned, with keep_out having its top H+D bits set and last_out=1.
- The state shall then return to IDLE.
REQ-011 For a last input fire with H+D > DATA_BYTE_WD the block SHALL emit a full beat with last_out=0, then go to TAIL with ready_in=0.
- TAIL shall emit the H+D-DATA_BYTE_WD remaining bytes with last_out=1 when the output register frees, then return to IDLE.
REQ-012 Byte lanes with keep_out=0 SHALL read 0 in data_out.
REQ-013 Output SHALL be registered with full backpressure:
- while valid_out=1 and ready_out=0, data_out, keep_out and last_out stay stable;
- valid_out deasserts only after a handshake with no new beat loaded.
REQ-014 Back-to-back throughput SHALL be one beat per cycle in STREAM when ready_out is held 1.
- Latency from input fire to valid_out shall be 1 cycle.
REQ-015 A new header SHALL be accepted in the IDLE cycle right after the last beat is loaded.
- The next packet's first output shall appear no earlier than the cycle after the previous last_out handshake.
REQ-016 valid_in asserted in IDLE SHALL be held off with ready_in=0, never dropped.
REQ-017 keep_in SHALL be all ones on non-last beats; any other value there is a protocol violation, and behaviour is undefined.
REQ-018 pkt_done SHALL equal valid_out && ready_out && last_out.
REQ-019 The byte count H+D SHALL be computed in ($clog2(DATA_BYTE_WD)+2) bits with no overflow.

Reset
REQ-020 rst_n low SHALL asynchronously force:
- state=IDLE, H=0 and R=0;
- valid_out=0, keep_out=0, data_out=0 and last_out=0;
- ready_in=0 and ready_insert=0 while rst_n is low.
REQ-021 ready_insert SHALL rise in the first clock cycle after rst_n deasserts.
REQ-022 Reset mid-packet SHALL discard all in-flight bytes, and no partial beat shall be emitted afterwards.

Verification (DATA_WD=32)
REQ-023 Test: header 0x0000BBBB, keep 0011; data 0x11223344, 0x55667788 (keep 1111), then 0x99AA0000 (keep 1100, last).
- Required output: 0xBBBB1122 and 0x33445566 (keep 1111), then 0x778899AA (keep 1111, last), with pkt_done on that beat.
REQ-024 Test: header 0x00CCDDEE, keep 0111; single data 0x11223344 (keep 1111, last).
- Required output: 0xCCDDEE11 (keep 1111, last 0), then 0x22334400 (keep 1110, last 1).
REQ-025 Test: header keep 0000 with HDR_ALLOW_EMPTY=1; data 0xDEADBEEF (keep 1111) then 0xCAFE0000 (keep 1100, last).
- Required output: identical beats and keeps, last on the second beat.
REQ-026 Test: case of REQ-023 with ready_out toggling randomly 50%.
- Required: identical output sequence, outputs stable while stalled, and no input accepted while the output register is full and stalled.
REQ-027 Test: two packets back-to-back, the second with header keep 1111 (0xA1A2A3A4) and data 0x01020304 (keep 1000, last).
- Required second-packet output: 0xA1A2A3A4 (keep 1111, last 0), then 0x01000000 (keep 1000, last 1).
REQ-028 Test: assert rst_n low during the STREAM state of REQ-023.
- Required: valid_out=0 immediately, and after release ready_insert=1 with a clean new packet matching REQ-024.
